// File: rtl/iosys_pkg.sv
// Shared types and constants for the IOSys memory-port arbiter.
// Grant codes double as the requester index on the grant output.
package iosys_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GNT_BOOT = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_DMA  = 2'd2,
        GNT_NONE = 2'd3
    } grant_e;

    localparam logic [31:0] ABORT_DATA = 32'hFFFF_FFFF;

    function automatic logic [2:0] grant_onehot(input grant_e g);
        case (g)
            GNT_BOOT: return 3'b001;
            GNT_CPU:  return 3'b010;
            GNT_DMA:  return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin chooser; the parent owns and updates the last pointer.
// On a tie the side that was not served last (last_b_i: 1 = side b) wins.
module rr_pick2 (
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic last_b_i,
    output logic any_o,
    output logic pick_b_o
);

    assign any_o    = req_a_i | req_b_i;
    assign pick_b_o = req_b_i & (~req_a_i | ~last_b_i);

endmodule

// File: rtl/iosys_mem_arb.sv
// Three-way arbiter (boot > round-robin cpu/dma) onto the single RV memory port,
// with a watchdog that aborts accesses the memory never completes.
module iosys_mem_arb
    import iosys_pkg::*;
#(
    parameter int unsigned ADDR_W  = 23,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    input  logic [3:0]        req0_wstrb,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [31:0]       req1_wdata,
    input  logic [3:0]        req1_wstrb,
    output logic              req1_ready,

    input  logic              req2_valid,
    input  logic [ADDR_W-1:0] req2_addr,
    input  logic [31:0]       req2_wdata,
    input  logic [3:0]        req2_wstrb,
    output logic              req2_ready,

    output logic [31:0]       req_rdata,
    input  logic              ram_busy,

    output logic              rv_valid,
    output logic [ADDR_W-1:0] rv_addr,
    output logic [31:0]       rv_wdata,
    output logic [3:0]        rv_wstrb,
    input  logic [31:0]       rv_rdata,
    input  logic              rv_ready,

    output logic [1:0]        grant,
    output logic              err_timeout
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    grant_e              grant_q, grant_d;
    logic                last_q, last_d;       // 1 = dma served last
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                rv_valid_q, rv_valid_d;
    logic [ADDR_W-1:0]   rv_addr_q, rv_addr_d;
    logic [31:0]         rv_wdata_q, rv_wdata_d;
    logic [3:0]          rv_wstrb_q, rv_wstrb_d;
    logic [2:0]          ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic rr_any;
    logic rr_pick_dma;

    rr_pick2 u_rr (
        .req_a_i  (req1_valid),
        .req_b_i  (req2_valid),
        .last_b_i (last_q),
        .any_o    (rr_any),
        .pick_b_o (rr_pick_dma)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        wd_d       = wd_q;
        rv_valid_d = rv_valid_q;
        rv_addr_d  = rv_addr_q;
        rv_wdata_d = rv_wdata_q;
        rv_wstrb_d = rv_wstrb_q;
        ready_d    = '0;
        rdata_d    = rdata_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (!ram_busy && (req0_valid || rr_any)) begin
                    state_d    = ST_BUSY;
                    rv_valid_d = 1'b1;
                    wd_d       = '0;
                    if (req0_valid) begin
                        grant_d    = GNT_BOOT;
                        rv_addr_d  = req0_addr;
                        rv_wdata_d = req0_wdata;
                        rv_wstrb_d = req0_wstrb;
                    end else if (rr_pick_dma) begin
                        grant_d    = GNT_DMA;
                        rv_addr_d  = req2_addr;
                        rv_wdata_d = req2_wdata;
                        rv_wstrb_d = req2_wstrb;
                    end else begin
                        grant_d    = GNT_CPU;
                        rv_addr_d  = req1_addr;
                        rv_wdata_d = req1_wdata;
                        rv_wstrb_d = req1_wstrb;
                    end
                end
            end
            ST_BUSY: begin
                if (rv_ready) begin
                    state_d    = ST_GAP;
                    rv_valid_d = 1'b0;
                    rdata_d    = rv_rdata;
                    ready_d    = grant_onehot(grant_q);
                    if (grant_q == GNT_CPU) last_d = 1'b0;
                    else if (grant_q == GNT_DMA) last_d = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    // Abort: complete the requester with poison data; writes are dropped.
                    state_d    = ST_GAP;
                    rv_valid_d = 1'b0;
                    rdata_d    = ABORT_DATA;
                    ready_d    = grant_onehot(grant_q);
                    err_d      = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            grant_q    <= GNT_NONE;
            last_q     <= 1'b1;
            wd_q       <= '0;
            rv_valid_q <= 1'b0;
            rv_addr_q  <= '0;
            rv_wdata_q <= '0;
            rv_wstrb_q <= '0;
            ready_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            wd_q       <= wd_d;
            rv_valid_q <= rv_valid_d;
            rv_addr_q  <= rv_addr_d;
            rv_wdata_q <= rv_wdata_d;
            rv_wstrb_q <= rv_wstrb_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign req0_ready  = ready_q[0];
    assign req1_ready  = ready_q[1];
    assign req2_ready  = ready_q[2];
    assign req_rdata   = rdata_q;
    assign rv_valid    = rv_valid_q;
    assign rv_addr     = rv_addr_q;
    assign rv_wdata    = rv_wdata_q;
    assign rv_wstrb    = rv_wstrb_q;
    assign grant       = grant_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_iosys_mem_arb.sv
// Directed-vector bench for iosys_mem_arb; inputs driven and outputs sampled on
// the falling edge, so a value driven in cycle X is taken at the end of cycle X.
module tb_iosys_mem_arb;

    localparam int unsigned ADDR_W  = 23;
    localparam int unsigned TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              req0_valid = 1'b0, req1_valid = 1'b0, req2_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0, req2_addr = '0;
    logic [31:0]       req0_wdata = '0, req1_wdata = '0, req2_wdata = '0;
    logic [3:0]        req0_wstrb = '0, req1_wstrb = '0, req2_wstrb = '0;
    logic              req0_ready, req1_ready, req2_ready;
    logic [31:0]       req_rdata;
    logic              ram_busy = 1'b0;
    logic              rv_valid;
    logic [ADDR_W-1:0] rv_addr;
    logic [31:0]       rv_wdata;
    logic [3:0]        rv_wstrb;
    logic [31:0]       rv_rdata = '0;
    logic              rv_ready = 1'b0;
    logic [1:0]        grant;
    logic              err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    iosys_mem_arb #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_wstrb  (req0_wstrb),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_wstrb  (req1_wstrb),
        .req1_ready  (req1_ready),
        .req2_valid  (req2_valid),
        .req2_addr   (req2_addr),
        .req2_wdata  (req2_wdata),
        .req2_wstrb  (req2_wstrb),
        .req2_ready  (req2_ready),
        .req_rdata   (req_rdata),
        .ram_busy    (ram_busy),
        .rv_valid    (rv_valid),
        .rv_addr     (rv_addr),
        .rv_wdata    (rv_wdata),
        .rv_wstrb    (rv_wstrb),
        .rv_rdata    (rv_rdata),
        .rv_ready    (rv_ready),
        .grant       (grant),
        .err_timeout (err_timeout)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        tick; tick;
        n_cmp++; if (rv_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rv_valid: got %b want 0", rv_valid); end
        n_cmp++; if ({rv_addr, rv_wdata, rv_wstrb} !== '0) begin n_bad++; $display("FAIL reset_rv_bus: got %h/%h/%h want 0", rv_addr, rv_wdata, rv_wstrb); end
        n_cmp++; if ({req2_ready, req1_ready, req0_ready} !== 3'b000) begin n_bad++; $display("FAIL reset_ready: got %b want 000", {req2_ready, req1_ready, req0_ready}); end
        n_cmp++; if (req_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", req_rdata); end
        n_cmp++; if (grant !== 2'd3) begin n_bad++; $display("FAIL reset_grant: got %0d want 3", grant); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_timeout); end
        resetn = 1'b1;
        tick;
    endtask

    task automatic test_cpu_read;
        req1_addr = 23'h000100; req1_wstrb = 4'h0; req1_valid = 1'b1;   // cycle T
        tick;                                                            // T+1
        n_cmp++; if (rv_valid !== 1'b1 || grant !== 2'd1) begin n_bad++; $display("FAIL cpu_grant: got valid=%b grant=%0d want 1/1", rv_valid, grant); end
        n_cmp++; if (rv_addr !== 23'h000100 || rv_wstrb !== 4'h0) begin n_bad++; $display("FAIL cpu_latch: got %h/%h want 000100/0", rv_addr, rv_wstrb); end
        tick;                                                            // T+2
        n_cmp++; if (rv_valid !== 1'b1 || {req2_ready, req1_ready, req0_ready} !== 3'b000) begin n_bad++; $display("FAIL cpu_wait: got valid=%b ready=%b want 1/000", rv_valid, {req2_ready, req1_ready, req0_ready}); end
        tick;                                                            // T+3
        n_cmp++; if (rv_valid !== 1'b1) begin n_bad++; $display("FAIL cpu_hold: got %b want 1", rv_valid); end
        rv_ready = 1'b1; rv_rdata = 32'h12345678;
        tick;                                                            // T+4 GAP
        rv_ready = 1'b0; rv_rdata = '0;
        n_cmp++; if ({req2_ready, req1_ready, req0_ready} !== 3'b010) begin n_bad++; $display("FAIL cpu_ready: got %b want 010", {req2_ready, req1_ready, req0_ready}); end
        n_cmp++; if (req_rdata !== 32'h12345678) begin n_bad++; $display("FAIL cpu_rdata: got %h want 12345678", req_rdata); end
        n_cmp++; if (rv_valid !== 1'b0) begin n_bad++; $display("FAIL cpu_gap_valid: got %b want 0", rv_valid); end
        req1_valid = 1'b0;
        tick;                                                            // T+5 IDLE
        n_cmp++; if (req1_ready !== 1'b0 || grant !== 2'd3) begin n_bad++; $display("FAIL cpu_idle: got ready=%b grant=%0d want 0/3", req1_ready, grant); end
    endtask

    task automatic test_boot_cpu;
        req0_addr = 23'h000040; req0_wdata = 32'hA5A5_A5A5; req0_wstrb = 4'hF;
        req1_addr = 23'h000200; req1_wstrb = 4'h0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick;
        n_cmp++; if (grant !== 2'd0 || rv_addr !== 23'h000040) begin n_bad++; $display("FAIL boot_first: got grant=%0d addr=%h want 0/000040", grant, rv_addr); end
        n_cmp++; if (rv_wdata !== 32'hA5A5_A5A5 || rv_wstrb !== 4'hF) begin n_bad++; $display("FAIL boot_wdata: got %h/%h want a5a5a5a5/f", rv_wdata, rv_wstrb); end
        rv_ready = 1'b1;
        tick;                                                            // GAP
        rv_ready = 1'b0;
        n_cmp++; if ({req2_ready, req1_ready, req0_ready} !== 3'b001) begin n_bad++; $display("FAIL boot_ready: got %b want 001", {req2_ready, req1_ready, req0_ready}); end
        req0_valid = 1'b0;
        tick;                                                            // IDLE
        n_cmp++; if (grant !== 2'd3 || rv_valid !== 1'b0) begin n_bad++; $display("FAIL boot_idle: got grant=%0d valid=%b want 3/0", grant, rv_valid); end
        tick;
        n_cmp++; if (grant !== 2'd1 || rv_addr !== 23'h000200 || rv_valid !== 1'b1) begin n_bad++; $display("FAIL boot_then_cpu: got grant=%0d addr=%h valid=%b want 1/000200/1", grant, rv_addr, rv_valid); end
        rv_ready = 1'b1; rv_rdata = 32'hCAFE_F00D;
        tick;
        rv_ready = 1'b0;
        n_cmp++; if (req1_ready !== 1'b1 || req_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL boot_cpu_done: got ready=%b rdata=%h want 1/cafef00d", req1_ready, req_rdata); end
        req1_valid = 1'b0;
        tick;
    endtask

    task automatic test_rr;
        logic [1:0]        exp_g;
        logic [ADDR_W-1:0] exp_a;
        logic [2:0]        exp_r;
        logic [31:0]       exp_d;
        resetn = 1'b0; tick; resetn = 1'b1; tick;
        req1_addr = 23'h000300; req1_wstrb = 4'h0;
        req2_addr = 23'h000400; req2_wstrb = 4'h0;
        req1_valid = 1'b1; req2_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'd1 : 2'd2;
            exp_a = (i % 2 == 0) ? 23'h000300 : 23'h000400;
            exp_r = (i % 2 == 0) ? 3'b010 : 3'b100;
            exp_d = 32'h0000_0100 + 32'(i);
            tick;                                                        // BUSY
            n_cmp++; if (grant !== exp_g || rv_valid !== 1'b1 || rv_addr !== exp_a) begin n_bad++; $display("FAIL rr_grant[%0d]: got grant=%0d valid=%b addr=%h want %0d/1/%h", i, grant, rv_valid, rv_addr, exp_g, exp_a); end
            rv_ready = 1'b1; rv_rdata = exp_d;
            tick;                                                        // GAP
            rv_ready = 1'b0;
            n_cmp++; if ({req2_ready, req1_ready, req0_ready} !== exp_r || req_rdata !== exp_d) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b/%h want %b/%h", i, {req2_ready, req1_ready, req0_ready}, req_rdata, exp_r, exp_d); end
            if (i == 3) begin req1_valid = 1'b0; req2_valid = 1'b0; end
            tick;                                                        // IDLE
        end
    endtask

    task automatic test_ram_busy;
        ram_busy = 1'b1; req1_addr = 23'h000500; req1_wstrb = 4'h0; req1_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick;
            n_cmp++; if (rv_valid !== 1'b0 || grant !== 2'd3) begin n_bad++; $display("FAIL busy_hold[%0d]: got valid=%b grant=%0d want 0/3", i, rv_valid, grant); end
        end
        ram_busy = 1'b0;
        tick;
        n_cmp++; if (rv_valid !== 1'b1 || grant !== 2'd1 || rv_addr !== 23'h000500) begin n_bad++; $display("FAIL busy_release: got valid=%b grant=%0d addr=%h want 1/1/000500", rv_valid, grant, rv_addr); end
        ram_busy = 1'b1;
        tick; tick;
        n_cmp++; if (rv_valid !== 1'b1) begin n_bad++; $display("FAIL busy_no_abort: got %b want 1", rv_valid); end
        rv_ready = 1'b1; rv_rdata = 32'h55AA_0001;
        tick;
        rv_ready = 1'b0;
        n_cmp++; if (req1_ready !== 1'b1 || req_rdata !== 32'h55AA_0001) begin n_bad++; $display("FAIL busy_done: got ready=%b rdata=%h want 1/55aa0001", req1_ready, req_rdata); end
        req1_valid = 1'b0; ram_busy = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL to_pre_err: got %b want 0", err_timeout); end
        req1_addr = 23'h000600; req1_wdata = 32'hDEAD_BEEF; req1_wstrb = 4'hF; req1_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick;
            n_cmp++; if (rv_valid !== 1'b1 || req1_ready !== 1'b0) begin n_bad++; $display("FAIL to_wait[%0d]: got valid=%b ready=%b want 1/0", k, rv_valid, req1_ready); end
        end
        tick;                                                            // T+17 GAP
        n_cmp++; if (rv_valid !== 1'b0 || {req2_ready, req1_ready, req0_ready} !== 3'b010) begin n_bad++; $display("FAIL to_abort: got valid=%b ready=%b want 0/010", rv_valid, {req2_ready, req1_ready, req0_ready}); end
        n_cmp++; if (req_rdata !== 32'hFFFF_FFFF || err_timeout !== 1'b1) begin n_bad++; $display("FAIL to_data: got %h err=%b want ffffffff/1", req_rdata, err_timeout); end
        req1_valid = 1'b0;
        rv_ready = 1'b1; rv_rdata = 32'h0BAD_0BAD;                       // stale in GAP and IDLE
        tick;
        n_cmp++; if (grant !== 2'd3 || req1_ready !== 1'b0 || req_rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL to_stale_gap: got grant=%0d ready=%b rdata=%h want 3/0/ffffffff", grant, req1_ready, req_rdata); end
        tick;
        rv_ready = 1'b0;
        n_cmp++; if (rv_valid !== 1'b0 || {req2_ready, req1_ready, req0_ready} !== 3'b000 || req_rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL to_stale_idle: got valid=%b ready=%b rdata=%h want 0/000/ffffffff", rv_valid, {req2_ready, req1_ready, req0_ready}, req_rdata); end
        repeat (5) tick;
        n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", err_timeout); end
    endtask

    task automatic test_reset_mid;
        req1_addr = 23'h000700; req1_wstrb = 4'h3; req1_valid = 1'b1;
        tick;
        n_cmp++; if (rv_valid !== 1'b1 || rv_wstrb !== 4'h3) begin n_bad++; $display("FAIL rst_mid_busy: got valid=%b wstrb=%h want 1/3", rv_valid, rv_wstrb); end
        resetn = 1'b0; req1_valid = 1'b0;
        tick;
        n_cmp++; if (rv_valid !== 1'b0 || {rv_addr, rv_wdata, rv_wstrb} !== '0) begin n_bad++; $display("FAIL rst_mid_bus: got valid=%b %h/%h/%h want 0", rv_valid, rv_addr, rv_wdata, rv_wstrb); end
        n_cmp++; if (grant !== 2'd3 || err_timeout !== 1'b0 || req_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_mid_state: got grant=%0d err=%b rdata=%h want 3/0/0", grant, err_timeout, req_rdata); end
        resetn = 1'b1; rv_ready = 1'b1; rv_rdata = 32'h7777_7777;
        tick;
        rv_ready = 1'b0;
        n_cmp++; if (rv_valid !== 1'b0 || {req2_ready, req1_ready, req0_ready} !== 3'b000 || req_rdata !== 32'h0 || grant !== 2'd3) begin n_bad++; $display("FAIL rst_late_ready: got valid=%b ready=%b rdata=%h grant=%0d want 0/000/0/3", rv_valid, {req2_ready, req1_ready, req0_ready}, req_rdata, grant); end
        tick;
    endtask

    initial begin
        test_reset;
        test_cpu_read;
        test_boot_cpu;
        test_rr;
        test_ram_busy;
        test_timeout;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
